// File: rtl/lessthan32_seq_pkg.sv
// Shared ALU definitions for the bit-serial set-less-than unit.
package lessthan32_seq_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned IDX_W_DEF = $clog2(WIDTH_DEF);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/lessthan32_seq_ctrl.sv
// Sequencer for the bit-serial compare: IDLE/SCAN/DONE FSM plus MSB-first bit index.
module lessthan32_seq_ctrl
    import lessthan32_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_eq,
    output logic [IDX_W-1:0] idx,
    output logic             load_c,
    output logic             dec_c,
    output logic             finish_c,
    output logic             busy,
    output logic             done
);

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Next state and datapath strobes; a scan ends on the first differing bit or at bit 0
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        dec_c     = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (!bit_eq || idx == '0) begin
                    finish_c  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    dec_c = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, handshake flags and index; busy/done are registered off the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= IDX_W'(WIDTH - 1);
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SCAN);
            done  <= (state_nxt == DONE);
            if (load_c) begin
                idx <= IDX_W'(WIDTH - 1);
            end else if (dec_c) begin
                idx <= idx - IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/lessthan32_seq.sv
// Multi-cycle bit-serial set-less-than (slt/sltu) with start/busy/done handshake.
module lessthan32_seq
    import lessthan32_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;
    logic             load_c;
    logic             dec_c;
    logic             finish_c;
    logic             a_bit_c;
    logic             b_bit_c;
    logic             bit_eq_c;
    logic             at_msb_c;
    logic             lt_c;

    lessthan32_seq_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bit_eq   (bit_eq_c),
        .idx      (idx),
        .load_c   (load_c),
        .dec_c    (dec_c),
        .finish_c (finish_c),
        .busy     (busy),
        .done     (done)
    );

    // Per-bit decision: a differing sign bit inverts the sense in signed mode
    always_comb begin
        a_bit_c  = a_q[idx];
        b_bit_c  = b_q[idx];
        bit_eq_c = (a_bit_c == b_bit_c);
        at_msb_c = (idx == IDX_W'(WIDTH - 1));
        lt_c     = !bit_eq_c && ((SIGNED && at_msb_c) ? a_bit_c : !a_bit_c);
    end

    // Operand capture on accept; result updates only on the decision cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            out <= '0;
        end else begin
            if (load_c) begin
                a_q <= a;
                b_q <= b;
            end
            if (finish_c) begin
                out <= WIDTH'(lt_c);
            end
        end
    end

endmodule

// File: tb/tb_lessthan32_seq.sv
// Randomized self-checking bench for lessthan32_seq (signed and unsigned instances).
module tb_lessthan32_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy_s, done_s, busy_u, done_u;
    logic [31:0] out_s, out_u;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prev_s = '0;
    logic [31:0] prev_u = '0;

    always #5 clk = ~clk;

    lessthan32_seq #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_s), .done(done_s), .out(out_s)
    );

    lessthan32_seq #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_u), .done(done_u), .out(out_u)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: cycles from accept to decision are set by the highest differing bit
    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] d;
        d = x ^ y;
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 32 - i;
        end
        return 32;
    endfunction

    function automatic logic [31:0] ref_slt(input logic [31:0] x, input logic [31:0] y);
        return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] ref_sltu(input logic [31:0] x, input logic [31:0] y);
        return (x < y) ? 32'd1 : 32'd0;
    endfunction

    // Called #1 after an edge; the next edge accepts the compare.
    // poke injects a start with other operands 3 cycles into the scan.
    task automatic do_cmp(input logic [31:0] av, input logic [31:0] bv,
                          input bit keep_start, input bit poke);
        int n;
        int busy_cnt;
        int lat;
        a = av;
        b = bv;
        start = 1'b1;
        lat = ref_lat(av, bv);
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        check("busy_after_accept", 32'(busy_s), 32'd1);
        if (lat > 1) check("out_held_during_scan", out_s, prev_s);
        busy_cnt = busy_s ? 1 : 0;
        n = 0;
        while (!done_s && n < 40) begin
            if (poke && n == 3) begin
                a = $urandom;
                b = $urandom;
                start = 1'b1;
            end else if (poke && n == 4) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            if (!done_s && busy_s) busy_cnt++;
        end
        check("latency", 32'(n), 32'(lat));
        check("busy_cycles", 32'(busy_cnt), 32'(lat));
        check("busy_low_in_done", 32'(busy_s), 32'd0);
        check("done_u_aligned", 32'(done_u), 32'd1);
        check("out_signed", out_s, ref_slt(av, bv));
        check("out_unsigned", out_u, ref_sltu(av, bv));
        prev_s = ref_slt(av, bv);
        prev_u = ref_sltu(av, bv);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done_s), 32'd0);
        check("idle_not_busy", 32'(busy_s), 32'd0);
        check("out_held_after", out_s, prev_s);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int seen;

        #2;
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_done", 32'(done_s), 32'd0);
        check("rst_out", out_s, 32'd0);
        check("rst_out_u", out_u, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_cmp(32'h42220225, 32'h4002028A, 1'b0, 1'b0);
        do_cmp(32'h00000005, 32'h00000006, 1'b0, 1'b0);
        do_cmp(32'h00000006, 32'h00000005, 1'b0, 1'b0);
        do_cmp(32'h12345678, 32'h12345678, 1'b0, 1'b0);
        do_cmp(32'h80000000, 32'h00000001, 1'b0, 1'b0);
        do_cmp(32'h00000001, 32'h80000000, 1'b0, 1'b0);

        // Ignored start mid-scan
        do_cmp(32'h00000005, 32'h00000006, 1'b0, 1'b1);

        // Async reset mid-scan
        a = 32'h00000005;
        b = 32'h00000006;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_s), 32'd0);
        check("midrst_done", 32'(done_s), 32'd0);
        check("midrst_out", out_s, 32'd0);
        check("midrst_out_u", out_u, 32'd0);
        prev_s = '0;
        prev_u = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_s || busy_s) seen++;
        end
        check("no_done_after_rst", 32'(seen), 32'd0);
        do_cmp(32'h42220225, 32'h4002028A, 1'b0, 1'b0);

        // Back-to-back with start held high
        do_cmp(32'h42220225, 32'h4002028A, 1'b1, 1'b0);
        do_cmp(32'h80000000, 32'h00000001, 1'b0, 1'b0);

        // Random operands, fully random and single/few-bit differences
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case (i % 3)
                0:       rb = $urandom;
                1:       rb = ra ^ (32'd1 << $urandom_range(31, 0));
                default: rb = ra ^ (32'hFFFFFFFF >> $urandom_range(31, 0));
            endcase
            do_cmp(ra, rb, 1'b0, (i % 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
